// File: rtl/proc_int_pkg.sv
// Shared types and helpers for the multi-source interrupt controller.
package proc_int_pkg;

    localparam int unsigned ID_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        VECTOR,
        SERVICE,
        RETURN
    } int_state_t;

    // Full-width vector address; callers truncate to their PC width.
    function automatic logic [31:0] int_vector(
        input logic [ID_W-1:0] id,
        input logic [31:0]     base,
        input logic [31:0]     stride
    );
        return base + (32'(id) * stride);
    endfunction

endpackage

// File: rtl/proc_int_ctrl_pending.sv
// Edge capture, pending/enable registers and lowest-index priority pick.
module int_pending
    import proc_int_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               en_wr,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic [NUM_SRC-1:0] ack,
    output logic [NUM_SRC-1:0] pending,
    output logic               elig_valid,
    output logic [ID_W-1:0]    elig_id
);

    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;

    assign rise     = irq & ~irq_prev;
    assign eligible = pending & enable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_prev <= '0;
            pending  <= '0;
            enable   <= '1;
        end else begin
            irq_prev <= irq;
            // A fresh edge on a bit being acknowledged keeps it pending.
            pending  <= (pending & ~ack) | rise;
            if (en_wr) begin
                enable <= en_wdata;
            end
        end
    end

    always_comb begin
        elig_valid = 1'b0;
        elig_id    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !elig_valid) begin
                elig_valid = 1'b1;
                elig_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/proc_int_ctrl.sv
// Interrupt controller top: drain/vector/service/return sequencing and EPC.
module proc_int_ctrl
    import proc_int_pkg::*;
#(
    parameter int unsigned     NUM_SRC    = 4,
    parameter int unsigned     PC_W       = 16,
    parameter logic [PC_W-1:0] VEC_BASE   = 16'h0100,
    parameter logic [PC_W-1:0] VEC_STRIDE = 16'h0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               en_wr,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               halt,
    input  logic               pipe_empty,
    input  logic [PC_W-1:0]    epc_in,
    input  logic               rti,
    output logic               drain_req,
    output logic               redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_SRC-1:0] pending
);

    int_state_t        state;
    int_state_t        state_n;
    logic [PC_W-1:0]   epc_q;
    logic              elig_valid;
    logic [ID_W-1:0]   elig_id;
    logic              take;

    int_pending #(
        .NUM_SRC (NUM_SRC)
    ) u_pending (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .en_wr      (en_wr),
        .en_wdata   (en_wdata),
        .ack        (irq_ack),
        .pending    (pending),
        .elig_valid (elig_valid),
        .elig_id    (elig_id)
    );

    assign take = (state == DRAIN) && !halt && pipe_empty && elig_valid;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (elig_valid && !halt) state_n = DRAIN;
            DRAIN: begin
                if (halt)            state_n = IDLE;
                else if (pipe_empty) state_n = elig_valid ? VECTOR : IDLE;
            end
            VECTOR:  state_n = SERVICE;
            SERVICE: if (rti) state_n = RETURN;
            RETURN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            epc_q     <= '0;
            active_id <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                epc_q     <= epc_in;
                active_id <= elig_id;
            end
        end
    end

    always_comb begin
        drain_req   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        in_service  = 1'b0;
        case (state)
            DRAIN:   drain_req = 1'b1;
            VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = PC_W'(int_vector(active_id, 32'(VEC_BASE), 32'(VEC_STRIDE)));
            end
            SERVICE: in_service = 1'b1;
            RETURN: begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        irq_ack = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            irq_ack[i] = (state == VECTOR) && (active_id == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_proc_int_ctrl.sv
// Self-checking bench for proc_int_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_proc_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        en_wr;
    logic [3:0]  en_wdata;
    logic        halt;
    logic        pipe_empty;
    logic [15:0] epc_in;
    logic        rti;
    logic        drain_req;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [3:0]  irq_ack;
    logic        in_service;
    logic [3:0]  active_id;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    // Reference model: pending/enable sets and a handful of phase flags.
    logic [3:0]  m_pend, m_en, m_prev;
    logic        m_drain, m_vec, m_srv, m_ret;
    int          m_aid;
    logic [15:0] m_epc;

    proc_int_ctrl #(
        .NUM_SRC    (4),
        .PC_W       (16),
        .VEC_BASE   (16'h0100),
        .VEC_STRIDE (16'h0010)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .en_wr       (en_wr),
        .en_wdata    (en_wdata),
        .halt        (halt),
        .pipe_empty  (pipe_empty),
        .epc_in      (epc_in),
        .rti         (rti),
        .drain_req   (drain_req),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_ack     (irq_ack),
        .in_service  (in_service),
        .active_id   (active_id),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock: the model consumes the same inputs the DUT samples at this edge.
    task automatic step();
        logic        c_rst, c_enwr, c_halt, c_pe, c_rti;
        logic [3:0]  c_irq, c_enwd, rise, ack, elig;
        logic [15:0] c_epc;
        logic        n_drain, n_vec, n_srv, n_ret;
        c_rst = rst; c_irq = irq; c_enwr = en_wr; c_enwd = en_wdata;
        c_halt = halt; c_pe = pipe_empty; c_epc = epc_in; c_rti = rti;
        @(posedge clk);
        if (!c_rst) begin
            m_pend = '0; m_en = '1; m_prev = '0;
            m_drain = 0; m_vec = 0; m_srv = 0; m_ret = 0;
            m_aid = 0; m_epc = '0;
        end else begin
            rise = c_irq & ~m_prev;
            m_prev = c_irq;
            ack = m_vec ? (4'b0001 << m_aid) : 4'b0000;
            elig = m_pend & m_en;
            n_drain = 0; n_vec = 0; n_srv = 0; n_ret = 0;
            if (m_vec) n_srv = 1;
            else if (m_ret) n_srv = 0;
            else if (m_srv) begin
                if (c_rti) n_ret = 1; else n_srv = 1;
            end else if (m_drain) begin
                if (!c_halt) begin
                    if (!c_pe) n_drain = 1;
                    else if (elig != 0) begin
                        n_vec = 1; m_epc = c_epc; m_aid = lowest(elig);
                    end
                end
            end else if (elig != 0 && !c_halt) n_drain = 1;
            m_pend = (m_pend & ~ack) | rise;
            if (c_enwr) m_en = c_enwd;
            m_drain = n_drain; m_vec = n_vec; m_srv = n_srv; m_ret = n_ret;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        step(); step();
        checks++;
        if ({drain_req, redirect, redirect_pc, irq_ack, in_service, active_id, pending} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {drain_req, redirect, redirect_pc, irq_ack, in_service, active_id, pending});
        end
        rst = 1;
        step();
    endtask

    task automatic test_single();
        irq = 4'b0100; pipe_empty = 1; epc_in = 16'h0042;
        step();
        checks++;
        if (pending !== 4'b0100 || drain_req !== 1'b0) begin
            errors++; $display("FAIL single_pending got %b/%b exp 0100/0", pending, drain_req);
        end
        step();
        checks++;
        if (drain_req !== 1'b1) begin errors++; $display("FAIL single_drain got %b exp 1", drain_req); end
        step();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0120 || irq_ack !== 4'b0100) begin
            errors++; $display("FAIL single_vector got %b %h %b exp 1 0120 0100", redirect, redirect_pc, irq_ack);
        end
        irq = 4'b0000;
        step();
        checks++;
        if (in_service !== 1'b1 || pending !== 4'b0000 || redirect !== 1'b0) begin
            errors++; $display("FAIL single_service got %b %b %b exp 1 0000 0", in_service, pending, redirect);
        end
        rti = 1;
        step();
        rti = 0;
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0042) begin
            errors++; $display("FAIL single_return got %b %h exp 1 0042", redirect, redirect_pc);
        end
        step();
        checks++;
        if ({redirect, in_service, drain_req} !== 3'b000) begin
            errors++; $display("FAIL single_idle got %b exp 000", {redirect, in_service, drain_req});
        end
    endtask

    task automatic test_priority();
        irq = 4'b1010; pipe_empty = 1; epc_in = 16'h0200;
        step(); irq = 4'b0000;
        step(); step();
        checks++;
        if (redirect_pc !== 16'h0110 || irq_ack !== 4'b0010) begin
            errors++; $display("FAIL prio_first got %h %b exp 0110 0010", redirect_pc, irq_ack);
        end
        step();
        checks++;
        if (pending !== 4'b1000 || in_service !== 1'b1) begin
            errors++; $display("FAIL prio_pending got %b %b exp 1000 1", pending, in_service);
        end
        rti = 1; step(); rti = 0;
        step();
        checks++;
        if (drain_req !== 1'b0) begin errors++; $display("FAIL prio_gap got %b exp 0", drain_req); end
        step(); step();
        checks++;
        if (redirect_pc !== 16'h0130 || irq_ack !== 4'b1000) begin
            errors++; $display("FAIL prio_second got %h %b exp 0130 1000", redirect_pc, irq_ack);
        end
        step(); rti = 1; step(); rti = 0; step();
    endtask

    task automatic test_drain_wait();
        int cnt;
        pipe_empty = 0; irq = 4'b0001;
        step(); irq = 4'b0000;
        step();
        cnt = drain_req ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            epc_in = {1'b1, 15'($urandom)};
            step();
            if (drain_req) cnt++;
        end
        pipe_empty = 1; epc_in = 16'h0BEE;
        step();
        if (drain_req) cnt++;
        checks++;
        if (cnt !== 6) begin errors++; $display("FAIL drain_cycles got %0d exp 6", cnt); end
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0100) begin
            errors++; $display("FAIL drain_vector got %b %h exp 1 0100", redirect, redirect_pc);
        end
        epc_in = 16'h1234;
        step(); rti = 1; step(); rti = 0;
        checks++;
        if (redirect_pc !== 16'h0BEE) begin errors++; $display("FAIL drain_epc got %h exp 0bee", redirect_pc); end
        step();
    endtask

    task automatic test_masking();
        en_wr = 1; en_wdata = 4'b1110; step(); en_wr = 0;
        irq = 4'b0001; step(); irq = 4'b0000;
        step(); step();
        checks++;
        if (pending !== 4'b0001 || drain_req !== 1'b0) begin
            errors++; $display("FAIL mask_hold got %b %b exp 0001 0", pending, drain_req);
        end
        en_wr = 1; en_wdata = 4'b1111; step(); en_wr = 0;
        step();
        checks++;
        if (drain_req !== 1'b1) begin errors++; $display("FAIL mask_release got %b exp 1", drain_req); end
        step();
        checks++;
        if (redirect_pc !== 16'h0100 || irq_ack !== 4'b0001) begin
            errors++; $display("FAIL mask_vector got %h %b exp 0100 0001", redirect_pc, irq_ack);
        end
        step(); rti = 1; step(); rti = 0; step();
    endtask

    task automatic test_halt_abort();
        pipe_empty = 0; irq = 4'b0100; step(); irq = 4'b0000;
        step();
        halt = 1;
        step();
        checks++;
        if ({drain_req, redirect} !== 2'b00 || pending !== 4'b0100) begin
            errors++; $display("FAIL halt_abort got %b %b %b exp 0 0 0100", drain_req, redirect, pending);
        end
        step();
        checks++;
        if (drain_req !== 1'b0) begin errors++; $display("FAIL halt_block got %b exp 0", drain_req); end
        halt = 0; pipe_empty = 1;
        step(); step();
        checks++;
        if (redirect_pc !== 16'h0120) begin errors++; $display("FAIL halt_resume got %h exp 0120", redirect_pc); end
        step(); rti = 1; step(); rti = 0; step();
    endtask

    task automatic test_set_wins_reset();
        pipe_empty = 1; epc_in = 16'h0077; irq = 4'b0001;
        step(); irq = 4'b0000;
        step(); step();
        irq = 4'b0001;
        step();
        checks++;
        if (pending[0] !== 1'b1 || in_service !== 1'b1) begin
            errors++; $display("FAIL set_wins got %b %b exp 1 1", pending[0], in_service);
        end
        rst = 0;
        step();
        checks++;
        if ({drain_req, redirect, redirect_pc, irq_ack, in_service, active_id, pending} !== 31'd0) begin
            errors++;
            $display("FAIL reset_in_service got %h exp 0", {drain_req, redirect, redirect_pc, irq_ack, in_service, active_id, pending});
        end
        rst = 1; irq = 4'b0000;
        step();
    endtask

    task automatic test_random();
        logic [30:0] got, exp;
        logic [15:0] exp_pc;
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 499) != 0);
            irq        = 4'($urandom);
            en_wr      = ($urandom_range(0, 31) == 0);
            en_wdata   = 4'($urandom);
            halt       = ($urandom_range(0, 15) == 0);
            pipe_empty = ($urandom_range(0, 3) != 0);
            epc_in     = 16'($urandom);
            rti        = ($urandom_range(0, 3) == 0);
            step();
            exp_pc = m_vec ? 16'(16'h0100 + m_aid * 16'h0010) : (m_ret ? m_epc : 16'h0000);
            exp = {m_drain, m_vec | m_ret, exp_pc, (m_vec ? (4'b0001 << m_aid) : 4'b0000),
                   m_srv, 4'(m_aid), m_pend};
            got = {drain_req, redirect, redirect_pc, irq_ack, in_service, active_id, pending};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle %0d got %h exp %h", n, got, exp);
            end
        end
        rst = 1; irq = 0; en_wr = 0; halt = 0; rti = 0;
        step();
    endtask

    initial begin
        rst = 0; irq = 0; en_wr = 0; en_wdata = 0; halt = 0;
        pipe_empty = 0; epc_in = 0; rti = 0;
        test_reset();
        test_single();
        test_priority();
        test_drain_wait();
        test_masking();
        test_halt_abort();
        test_set_wins_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
